// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time from execute, drives a
// request/grant bus with registered outputs, aligns and extends load data for
// register write-back, and flags misaligned or timed-out accesses.
module lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rd_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // Last counter value before the op is abandoned (counter starts at 0).
  localparam logic [15:0] CNT_LAST = 16'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic        accept;
  logic        illegal;
  logic        timeout;
  logic        op_done;

  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        op_we;
  logic [31:0] op_addr;
  logic [4:0]  op_rd_addr;

  // Size 11, or a half/word whose address is not naturally aligned.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down, truncate to the op size and extend.
  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] a, input logic [31:0] d);
    logic signed [31:0] sh;
    sh = $signed(d >> {a, 3'b000});
    case (size)
      2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_ready_o = (state == IDLE);
  assign stall_o     = (state != IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign illegal     = is_illegal(req_size_i, req_addr_i[1:0]);
  // A grant in REQ or read data in WAIT completes the phase and wins over timeout.
  assign op_done     = ((state == REQ) & mem_gnt_i) | ((state == WAIT) & mem_rvalid_i);
  assign timeout     = (state != IDLE) & (cnt == CNT_LAST) & ~op_done;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && !illegal) state_nx = REQ;
      REQ: begin
        if (mem_gnt_i)    state_nx = op_we ? IDLE : WAIT;
        else if (timeout) state_nx = IDLE;
      end
      WAIT: if (mem_rvalid_i || timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Wait counter: counts while a phase lingers, clears on every state change
  always_ff @(posedge clk) begin
    if (rst)                                    cnt <= '0;
    else if (state_nx == state && state != IDLE) cnt <= cnt + 16'd1;
    else                                        cnt <= '0;
  end

  // Capture the op and the bus image at accept; bus outputs hold until grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_req_o <= (state_nx == REQ);
      if (accept && !illegal) begin
        mem_we_o    <= req_we_i;
        mem_be_o    <= byte_en(req_size_i, req_addr_i[1:0]);
        mem_addr_o  <= {req_addr_i[31:2], 2'b00};
        mem_wdata_o <= lane_rep(req_size_i, req_wdata_i);
      end
    end
  end

  // Op fields needed after the bus phase (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_we       <= req_we_i;
      op_size     <= req_size_i;
      op_unsigned <= req_unsigned_i;
      op_addr     <= req_addr_i;
      op_rd_addr  <= req_rd_addr_i;
    end
  end

  // Write-back and error pulses; each lasts a single cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen_o   <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      rd_wen_o <= 1'b0;
      err_o    <= 1'b0;
      if (accept && illegal) begin
        err_o      <= 1'b1;
        err_addr_o <= req_addr_i;
      end
      if (timeout) begin
        err_o      <= 1'b1;
        err_addr_o <= op_addr;
      end
      if (state == WAIT && mem_rvalid_i) begin
        rd_wen_o  <= (op_rd_addr != 5'd0);
        rd_addr_o <= op_rd_addr;
        rd_data_o <= load_ext(op_size, op_unsigned, op_addr[1:0], mem_rdata_i);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a default instance for the functional cases and a
// short-timeout instance (MAX_WAIT=4) sharing the same inputs.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd_addr = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        req_ready, mem_req, mem_we, rd_wen, stall, err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, rd_data, err_addr;
  logic [4:0]  rd_addr;

  logic        t_req_ready, t_mem_req, t_mem_we, t_rd_wen, t_stall, t_err;
  logic [3:0]  t_mem_be;
  logic [31:0] t_mem_addr, t_mem_wdata, t_rd_data, t_err_addr;
  logic [4:0]  t_rd_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_addr_i(req_rd_addr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .rd_wen_o(rd_wen), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .stall_o(stall), .err_o(err), .err_addr_o(err_addr)
  );

  lsu #(.MAX_WAIT(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(t_req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_addr_i(req_rd_addr),
    .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_be_o(t_mem_be), .mem_addr_o(t_mem_addr),
    .mem_wdata_o(t_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .rd_wen_o(t_rd_wen), .rd_addr_o(t_rd_addr), .rd_data_o(t_rd_data),
    .stall_o(t_stall), .err_o(t_err), .err_addr_o(t_err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Present one op for a single accept edge; returns in cycle N+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd_addr = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    tests++; if ({mem_req, mem_we, rd_wen, stall, err} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b want 00000", {mem_req, mem_we, rd_wen, stall, err}); end
    tests++; if ({mem_be, mem_addr, mem_wdata, rd_data, err_addr, rd_addr} !== '0) begin fails++; $display("FAIL reset_data: got nonzero want 0"); end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    do_reset();
    mem_gnt = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    tests++; if ({mem_req, mem_we, stall, req_ready} !== 4'b1010) begin fails++; $display("FAIL lw_req: got %b want 1010", {mem_req, mem_we, stall, req_ready}); end
    tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h want 00000100", mem_addr); end
    tests++; if (mem_be !== 4'b1111) begin fails++; $display("FAIL lw_be: got %b want 1111", mem_be); end
    tick();
    mem_gnt = 1'b0;
    tests++; if ({mem_req, stall, rd_wen} !== 3'b010) begin fails++; $display("FAIL lw_wait: got %b want 010", {mem_req, stall, rd_wen}); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    tests++; if ({rd_wen, rd_addr} !== {1'b1, 5'd5}) begin fails++; $display("FAIL lw_wen: got %b/%0d want 1/5", rd_wen, rd_addr); end
    tests++; if (rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h want deadbeef", rd_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL lw_noerr: got %b want 0", err); end
    tick();
    tests++; if ({rd_wen, req_ready} !== 2'b01) begin fails++; $display("FAIL lw_end: got %b want 01", {rd_wen, req_ready}); end
  endtask

  // Byte load from lane 3; the first REQ cycle carries a stray rvalid that must be ignored.
  task automatic test_lb(input logic uns, input logic [31:0] exp);
    do_reset();
    issue(1'b0, 2'b00, uns, 32'h203, 32'h0, 5'd9);
    tests++; if ({mem_be, mem_addr} !== {4'b1000, 32'h200}) begin fails++; $display("FAIL lb_be_addr: got %b %h want 1000 00000200", mem_be, mem_addr); end
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    tests++; if ({mem_req, rd_wen} !== 2'b10) begin fails++; $display("FAIL lb_rvalid_ignored: got %b want 10", {mem_req, rd_wen}); end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FFFFFF;
    tick();
    mem_rvalid = 1'b0;
    tests++; if ({rd_wen, rd_data} !== {1'b1, exp}) begin fails++; $display("FAIL lb_data_u%0b: got %b %h want 1 %h", uns, rd_wen, rd_data, exp); end
  endtask

  task automatic test_sh();
    do_reset();
    issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD, 5'd1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'b1100, 32'h300, 32'hABCDABCD}) begin
        fails++; $display("FAIL sh_hold%0d: got %b%b %b %h %h want 11 1100 00000300 abcdabcd", i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tests++; if ({mem_req, req_ready, stall} !== 3'b010) begin fails++; $display("FAIL sh_done: got %b want 010", {mem_req, req_ready, stall}); end
    tick();
    tests++; if ({rd_wen, err} !== 2'b00) begin fails++; $display("FAIL sh_nowb: got %b want 00", {rd_wen, err}); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    mem_gnt = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd0);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rd0_req: got %b want 1", mem_req); end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    mem_rvalid = 1'b0;
    tests++; if ({rd_wen, req_ready} !== 2'b01) begin fails++; $display("FAIL rd0_nowen: got %b want 01", {rd_wen, req_ready}); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h101, 32'h301, 32'h40};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sz[i], 1'b0, ad[i], 32'h0, 5'd4);
      tests++;
      if ({err, mem_req, req_ready, err_addr} !== {3'b101, ad[i]}) begin
        fails++; $display("FAIL misalign%0d: got %b%b%b %h want 101 %h", i, err, mem_req, req_ready, err_addr, ad[i]);
      end
      tick();
      tests++; if ({err, mem_req} !== 2'b00) begin fails++; $display("FAIL misalign%0d_pulse: got %b want 00", i, {err, mem_req}); end
    end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      tests++; if ({t_mem_req, t_err} !== 2'b10) begin fails++; $display("FAIL to_req%0d: got %b want 10", i, {t_mem_req, t_err}); end
      tick();
    end
    tests++; if ({t_err, t_req_ready, t_mem_req, t_rd_wen} !== 4'b1100) begin fails++; $display("FAIL to_err: got %b want 1100", {t_err, t_req_ready, t_mem_req, t_rd_wen}); end
    tests++; if (t_err_addr !== 32'h400) begin fails++; $display("FAIL to_addr: got %h want 00000400", t_err_addr); end
    tick();
    tests++; if (t_err !== 1'b0) begin fails++; $display("FAIL to_pulse: got %b want 0", t_err); end
    mem_gnt = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd7);
    tick();
    mem_gnt = 1'b0;
    tests++; if ({t_mem_req, t_stall} !== 2'b01) begin fails++; $display("FAIL rw_wait: got %b want 01", {t_mem_req, t_stall}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if ({t_req_ready, t_stall, t_mem_req, t_err, t_rd_wen} !== 5'b10000) begin fails++; $display("FAIL rw_reset: got %b want 10000", {t_req_ready, t_stall, t_mem_req, t_err, t_rd_wen}); end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    tests++; if ({t_rd_wen, t_err} !== 2'b00) begin fails++; $display("FAIL rw_late_rvalid: got %b want 00", {t_rd_wen, t_err}); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb(1'b0, 32'hFFFFFF80);
    test_lb(1'b1, 32'h00000080);
    test_sh();
    test_rd_zero();
    test_misaligned();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
